// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state encoding,
// header nibble and index/counter width functions.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first set request bit
// at or after i_ptr, wrapping modulo N.
module rr_select #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  int unsigned w_pos;
  logic [W-1:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_cand = W'(w_pos);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter serialising framed byte streams from
// N_REQ requesters into one UART TX FIFO. Define UART_ARB_HDR_EN to emit an owner header byte per frame.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned IDLE_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [8*N_REQ-1:0]            req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          wr_uart,
  output logic [7:0]                    w_data,
  input  logic                          tx_full,
  output logic [grant_width(N_REQ)-1:0] grant_id,
  output logic                          busy,
  output logic                          abort
);

  localparam int unsigned GW = grant_width(N_REQ);
  localparam int unsigned TW = count_width(IDLE_TIMEOUT);

  arb_state_t r_state;
  arb_state_t w_nstate;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] w_rr_ptr_n;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_grant_n;
  logic [GW-1:0] w_grant_inc;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_n;
  logic          r_abort;
  logic          w_abort_n;

  logic [GW-1:0] w_sel_idx;
  logic          w_sel_found;

  logic          w_own_valid;
  logic          w_own_last;
  logic [7:0]    w_own_data;
  logic          w_xfer;

  logic             w_wr;
  logic [7:0]       w_byte;
  logic [N_REQ-1:0] w_ready;

  rr_select #(
    .N (N_REQ),
    .W (GW)
  ) u_rr_select (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign w_grant_inc = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_xfer      = (r_state == S_DATA) && w_own_valid && !tx_full;

  always_comb begin
    w_nstate   = r_state;
    w_rr_ptr_n = r_rr_ptr;
    w_grant_n  = r_grant;
    w_tcnt_n   = r_tcnt;
    w_abort_n  = 1'b0;
    w_wr       = 1'b0;
    w_byte     = w_own_data;
    w_ready    = '0;

    case (r_state)
      S_IDLE: begin
        w_tcnt_n = '0;
        if (w_sel_found) begin
          w_grant_n = w_sel_idx;
`ifdef UART_ARB_HDR_EN
          w_nstate  = S_HDR;
`else
          w_nstate  = S_DATA;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        w_byte = {HDR_NIBBLE, 1'b0, 3'(r_grant)};
        if (!tx_full) begin
          w_wr     = 1'b1;
          w_nstate = S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (w_xfer) begin
          w_wr     = 1'b1;
          w_tcnt_n = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            w_ready[i] = (r_grant == GW'(i));
          end
          if (w_own_last) begin
            w_nstate   = S_IDLE;
            w_rr_ptr_n = w_grant_inc;
          end
        end else if (!tx_full) begin
          // Only owner-side stalls count; FIFO backpressure holds the counter.
          if (r_tcnt == TW'(IDLE_TIMEOUT - 1)) begin
            w_nstate   = S_IDLE;
            w_rr_ptr_n = w_grant_inc;
            w_abort_n  = 1'b1;
            w_tcnt_n   = '0;
          end else begin
            w_tcnt_n = r_tcnt + 1'b1;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase

    // The reset cycle must never leak a write or an accept.
    if (reset) begin
      w_wr    = 1'b0;
      w_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_tcnt   <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_rr_ptr <= w_rr_ptr_n;
      r_grant  <= w_grant_n;
      r_tcnt   <= w_tcnt_n;
      r_abort  <= w_abort_n;
    end
  end

  assign req_ready = w_ready;
  assign wr_uart   = w_wr;
  assign w_data    = w_byte;
  assign grant_id  = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign abort     = r_abort;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of byte-stream requesters sharing the UART transmitter (range 2..8).
REQ-002 Parameter IDLE_TIMEOUT, default 1023, SHALL set the cycles a granted requester may stall mid-frame before its grant is revoked.
REQ-003 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester byte valid.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  marks the final byte of a frame; qualified by req_valid.
REQ-008 req_ready  output  N_REQ  per-requester accept strobe; a byte transfers when valid and ready are both high.
REQ-009 wr_uart  output  1  one-cycle write strobe to the UART TX FIFO.
REQ-010 w_data  output  8  byte written with wr_uart.
REQ-011 tx_full  input  1  UART TX FIFO full.
REQ-012 grant_id  output  clog2(N_REQ)  index of the current owner; valid while busy is high.
REQ-013 busy  output  1  high while a frame is owned.
REQ-014 abort  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The FSM SHALL use states IDLE, HDR and DATA.
REQ-016 In IDLE with any req_valid high, the FSM SHALL select the first requester at or after rr_ptr (wrapping modulo N_REQ), register it as grant_id and raise busy on the next edge; no byte is accepted in the arbitration cycle.
REQ-017 rr_ptr SHALL become grant_id+1 (mod N_REQ) when a frame ends, so the last owner has the lowest priority next.
REQ-018 In DATA, req_ready[grant_id] and wr_uart SHALL be the combinational AND of state==DATA, req_valid[grant_id] and !tx_full; every other req_ready bit SHALL be 0.
REQ-019 w_data SHALL equal req_data of grant_id in DATA; bytes SHALL be written in order with no drop or duplication.
REQ-020 A transfer with req_last high SHALL return the FSM to IDLE on the next edge, clearing busy; back-to-back frames therefore have at least one idle cycle between them.
REQ-021 While tx_full is high, no write SHALL occur and the frame SHALL be held; tx_full stalls SHALL NOT advance the timeout counter.
REQ-022 The timeout counter SHALL clear on every transfer and increment each DATA cycle with req_valid[grant_id] low and tx_full low; on reaching IDLE_TIMEOUT the FSM SHALL pulse abort, advance rr_ptr and return to IDLE.
REQ-023 Requests arriving from non-owners mid-frame SHALL wait; the owner SHALL NOT be preempted except by timeout.
REQ-024 A frame of a single byte (valid and last together) SHALL be handled identically to longer frames.

Reset
REQ-025 On reset the FSM SHALL enter IDLE and set rr_ptr=0, grant_id=0, busy=0, abort=0, timeout counter=0; wr_uart and req_ready SHALL be 0 in the reset cycle.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without a write in that cycle and without an abort pulse.

Configuration
REQ-027 With UART_ARB_HDR_EN defined, IDLE SHALL transition to HDR; HDR SHALL write one header byte {4'hA, 1'b0, grant_id zero-extended to 3 bits} when !tx_full, then enter DATA.
REQ-028 Without UART_ARB_HDR_EN, IDLE SHALL transition directly to DATA and no header byte SHALL be emitted.

Structure
REQ-029 A shared package uart_arb_pkg SHALL hold the state enum, the header nibble constant 4'hA and the grant-index width function.
REQ-030 The round-robin selection SHALL be a sub-module rr_select (pure combinational: request vector and pointer in, index and found out).

Verification
REQ-031 Single requester 0 sends 3 bytes 0x11,0x22,0x33(last), tx_full=0 -> wr_uart pulses 3 consecutive cycles with those bytes, busy falls after the third.
REQ-032 Requesters 0 and 2 both valid from reset -> frame of 0 first, then 2; repeat -> 2 has been last owner, so 0 wins again only after 2 finishes.
REQ-033 tx_full held high 20 cycles mid-frame -> no writes, no abort, frame resumes and completes intact.
REQ-034 With IDLE_TIMEOUT=8, owner drops valid after 1 byte -> abort pulses exactly once 8 cycles later, busy=0, next requester is granted.
REQ-035 UART_ARB_HDR_EN defined, requester 3 sends 0x5A(last) -> writes 0xA3 then 0x5A.
REQ-036 Reset asserted during byte 2 of a 4-byte frame -> no further writes, all outputs at reset values, next grant to requester 0.
